// File: rtl/dmem_responder.sv
// dmem_responder: target end of the core's load/store data interface.
// Accepts one word-aligned request at a time, inserts WAIT_CYCLES wait
// states, then presents data or an error on a valid/ready response channel.
// Optional build macro DMEM_ERR_LOG_EN adds err_sticky/err_addr error logging.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
`ifdef DMEM_ERR_LOG_EN
  ,
  output logic        err_sticky,
  output logic [31:0] err_addr
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } stateE;

  stateE             stateR;
  stateE             nextStateS;
  logic [3:0]        waitCntR;
  logic              capWriteR;
  logic [31:0]       capAddrR;
  logic [31:0]       capWdataR;
  logic [3:0]        capBeR;
  logic              reqReadyR;
  logic              respValidR;
  logic [31:0]       respRdataR;
  logic              respErrR;

  logic              acceptS;
  logic              accessS;
  logic              accWriteS;
  logic [31:0]       accAddrS;
  logic [31:0]       accWdataS;
  logic [3:0]        accBeS;
  logic              accErrS;
  logic [IDX_W-1:0]  accIdxS;

  logic [31:0]       mem [DEPTH_WORDS];

  assign acceptS = (stateR == IDLE) && req_valid && reqReadyR;

  // Next-state logic and access strobe; a zero-wait access uses live request fields
  always_comb begin
    nextStateS = stateR;
    accessS    = 1'b0;
    accWriteS  = capWriteR;
    accAddrS   = capAddrR;
    accWdataS  = capWdataR;
    accBeS     = capBeR;
    case (stateR)
      IDLE: begin
        accWriteS = req_write;
        accAddrS  = req_addr;
        accWdataS = req_wdata;
        accBeS    = req_be;
        if (acceptS) begin
          nextStateS = (WAIT_CYCLES == 0) ? RESP : BUSY;
          accessS    = (WAIT_CYCLES == 0);
        end else begin
          nextStateS = IDLE;
        end
      end
      BUSY: begin
        if (waitCntR <= 4'd1) begin
          nextStateS = RESP;
          accessS    = 1'b1;
        end else begin
          nextStateS = BUSY;
        end
      end
      RESP: begin
        if (resp_ready) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = RESP;
        end
      end
      default: begin
        nextStateS = IDLE;
      end
    endcase
  end

  // Error classification and word index of the access in flight
  always_comb begin
    accErrS = (accAddrS[1:0] != 2'b00) || (accAddrS[31:2] >= 30'(DEPTH_WORDS));
    accIdxS = accAddrS[IDX_W+1:2];
  end

  // State, counter, capture and response registers; reset aborts any transaction
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateR     <= IDLE;
      waitCntR   <= 4'd0;
      capWriteR  <= 1'b0;
      capAddrR   <= 32'd0;
      capWdataR  <= 32'd0;
      capBeR     <= 4'd0;
      reqReadyR  <= 1'b1;
      respValidR <= 1'b0;
      respRdataR <= 32'd0;
      respErrR   <= 1'b0;
    end else begin
      stateR     <= nextStateS;
      reqReadyR  <= (nextStateS == IDLE);
      respValidR <= (nextStateS == RESP);
      if (acceptS) begin
        capWriteR <= req_write;
        capAddrR  <= req_addr;
        capWdataR <= req_wdata;
        capBeR    <= req_be;
        waitCntR  <= 4'(WAIT_CYCLES);
      end else if ((stateR == BUSY) && (waitCntR != 4'd0)) begin
        waitCntR <= waitCntR - 4'd1;
      end
      if (accessS) begin
        respErrR   <= accErrS;
        respRdataR <= (accErrS || accWriteS) ? 32'd0 : mem[accIdxS];
      end else if ((stateR == RESP) && resp_ready) begin
        respErrR   <= 1'b0;
        respRdataR <= 32'd0;
      end
    end
  end

  // Byte-enabled store into the array; contents survive reset
  always_ff @(posedge clk) begin
    if (reset && accessS && accWriteS && !accErrS) begin
      for (int b = 0; b < 4; b++) begin
        if (accBeS[b]) begin
          mem[accIdxS][8*b +: 8] <= accWdataS[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = reqReadyR;
  assign resp_valid = respValidR;
  assign resp_rdata = respRdataR;
  assign resp_err   = respErrR;

`ifdef DMEM_ERR_LOG_EN
  logic        errStickyR;
  logic [31:0] errAddrR;

  // Latch the address of the first erroring access since reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      errStickyR <= 1'b0;
      errAddrR   <= 32'd0;
    end else if (accessS && accErrS && !errStickyR) begin
      errStickyR <= 1'b1;
      errAddrR   <= accAddrS;
    end
  end

  assign err_sticky = errStickyR;
  assign err_addr   = errAddrR;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance
// for function/backpressure/reset checks and a WAIT_CYCLES=0 instance for
// back-to-back throughput. Honours DMEM_ERR_LOG_EN when defined.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        zReqValid, zReqReady, zReqWrite;
  logic [31:0] zReqAddr, zReqWdata;
  logic [3:0]  zReqBe;
  logic        zRespValid, zRespReady, zRespErr;
  logic [31:0] zRespRdata;

`ifdef DMEM_ERR_LOG_EN
  logic        err_sticky, zErrSticky;
  logic [31:0] err_addr, zErrAddr;
`endif

  int checkCount = 0;
  int errCount   = 0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef DMEM_ERR_LOG_EN
    ,
    .err_sticky (err_sticky),
    .err_addr   (err_addr)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dutZero (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (zReqValid),
    .req_ready  (zReqReady),
    .req_write  (zReqWrite),
    .req_addr   (zReqAddr),
    .req_wdata  (zReqWdata),
    .req_be     (zReqBe),
    .resp_valid (zRespValid),
    .resp_ready (zRespReady),
    .resp_rdata (zRespRdata),
    .resp_err   (zRespErr)
`ifdef DMEM_ERR_LOG_EN
    ,
    .err_sticky (zErrSticky),
    .err_addr   (zErrAddr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the WAIT_CYCLES=2 instance
  task automatic doTxn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] expData, input logic expErr);
    int n;
    checkVal({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    tick();
    req_valid = 1'b0; req_write = ~wr; req_addr = 32'hFFFF_FFFC;
    req_wdata = 32'h0BAD_0BAD; req_be = ~be;
    checkVal({tag, "_busyrdy"}, 32'(req_ready), 32'd0);
    n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    checkVal({tag, "_lat"}, 32'(n), 32'd2);
    checkVal({tag, "_data"}, resp_rdata, expData);
    checkVal({tag, "_err"}, 32'(resp_err), 32'(expErr));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkVal({tag, "_vclr"}, 32'(resp_valid), 32'd0);
    checkVal({tag, "_dclr"}, resp_rdata, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
    resp_ready = 1'b0;
    zReqValid = 1'b0; zReqWrite = 1'b0; zReqAddr = 32'd0; zReqWdata = 32'd0; zReqBe = 4'd0;
    zRespReady = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    checkVal("rst_ready", 32'(req_ready), 32'd1);
    checkVal("rst_valid", 32'(resp_valid), 32'd0);
    checkVal("rst_rdata", resp_rdata, 32'd0);
    checkVal("rst_err", 32'(resp_err), 32'd0);
`ifdef DMEM_ERR_LOG_EN
    checkVal("rst_sticky", 32'(err_sticky), 32'd0);
    checkVal("rst_eaddr", err_addr, 32'd0);
`endif

    // store/load, partial byte enables
    doTxn("st_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'd0, 1'b0);
    doTxn("ld_full", 1'b0, 32'h10, 32'd0, 4'b0000, 32'hDEAD_BEEF, 1'b0);
    doTxn("st_part", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'd0, 1'b0);
    doTxn("ld_part", 1'b0, 32'h10, 32'd0, 4'b1010, 32'hDE22_BE44, 1'b0);
    doTxn("st_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0);
    doTxn("ld_be0", 1'b0, 32'h10, 32'd0, 4'b0000, 32'hDE22_BE44, 1'b0);

    // errors and the last legal word
    doTxn("ld_mis", 1'b0, 32'h12, 32'd0, 4'b0000, 32'd0, 1'b1);
    doTxn("ld_oor", 1'b0, 32'h400, 32'd0, 4'b0000, 32'd0, 1'b1);
    doTxn("st_mis", 1'b1, 32'h11, 32'h7777_7777, 4'b1111, 32'd0, 1'b1);
    doTxn("ld_keep", 1'b0, 32'h10, 32'd0, 4'b0000, 32'hDE22_BE44, 1'b0);
`ifdef DMEM_ERR_LOG_EN
    checkVal("log_sticky", 32'(err_sticky), 32'd1);
    checkVal("log_eaddr", err_addr, 32'h12);
`endif
    doTxn("st_last", 1'b1, 32'h3FC, 32'hCAFE_F00D, 4'b1111, 32'd0, 1'b0);
    doTxn("ld_last", 1'b0, 32'h3FC, 32'd0, 4'b0000, 32'hCAFE_F00D, 1'b0);

    // backpressure: response held, second request waits with req_valid high
    begin
      int n;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'b0000;
      tick();
      req_addr = 32'h3FC;
      n = 0;
      while (!resp_valid && n < 20) begin
        tick();
        n++;
      end
      checkVal("bp_lat", 32'(n), 32'd2);
      for (int i = 0; i < 5; i++) begin
        tick();
        checkVal("bp_valid", 32'(resp_valid), 32'd1);
        checkVal("bp_data", resp_rdata, 32'hDE22_BE44);
        checkVal("bp_rdy", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      checkVal("bp_hs_valid", 32'(resp_valid), 32'd0);
      checkVal("bp_hs_rdy", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      checkVal("bp_acc2", 32'(req_ready), 32'd0);
      n = 0;
      while (!resp_valid && n < 20) begin
        tick();
        n++;
      end
      checkVal("bp_lat2", 32'(n), 32'd2);
      checkVal("bp_data2", resp_rdata, 32'hCAFE_F00D);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end

    // reset while BUSY aborts a store
    doTxn("st_zero", 1'b1, 32'h20, 32'h0000_0000, 4'b1111, 32'd0, 1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55AA_55AA; req_be = 4'b1111;
    tick();
    req_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkVal("abort_rdy", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkVal("abort_valid", 32'(resp_valid), 32'd0);
    end
`ifdef DMEM_ERR_LOG_EN
    checkVal("abort_sticky", 32'(err_sticky), 32'd0);
`endif
    doTxn("ld_abort", 1'b0, 32'h20, 32'd0, 4'b0000, 32'h0000_0000, 1'b0);

    // WAIT_CYCLES=0: store, then back-to-back loads at one per 2 cycles
    zRespReady = 1'b1;
    zReqValid = 1'b1; zReqWrite = 1'b1; zReqAddr = 32'h4; zReqWdata = 32'hA5A5_A5A5; zReqBe = 4'b1111;
    tick();
    checkVal("z_st_valid", 32'(zRespValid), 32'd1);
    checkVal("z_st_data", zRespRdata, 32'd0);
    zReqWrite = 1'b0; zReqWdata = 32'd0; zReqBe = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkVal("z_valid", 32'(zRespValid), 32'(i % 2));
      checkVal("z_rdy", 32'(zReqReady), 32'((i + 1) % 2));
      checkVal("z_data", zRespRdata, (i % 2 == 1) ? 32'hA5A5_A5A5 : 32'd0);
    end
    zReqValid = 1'b0;
    zRespReady = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
